// File: rtl/fsk_seq_pkg.sv
// Shared types and sizing helpers for the FSK symbol sequencer.
package fsk_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        TX    = 2'd3
    } seq_state_e;

    // Bytes needed to carry a full frame; a partly used last byte still counts.
    function automatic int nbytes(input int num_syms, input int sym_bits);
        return (num_syms * sym_bits + 7) / 8;
    endfunction

    function automatic int syms_per_byte(input int sym_bits);
        return 8 / sym_bits;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sym_period_timer.sv
// Symbol-period down-counter: expire marks the last cycle of each period
// and the count auto-reloads so back-to-back symbols have no gap.
module sym_period_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                expire
);

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_eff;

    assign period_eff = (period == '0) ? PERIOD_W'(1) : period;

    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        if (load) begin
            period_d = period_eff;
            cnt_d    = period_eff - PERIOD_W'(1);
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_d = period_q - PERIOD_W'(1);
            end else begin
                cnt_d = cnt_q - PERIOD_W'(1);
            end
        end
    end

    assign expire = en && !load && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_q <= PERIOD_W'(1);
            cnt_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/fsk_symbol_sequencer.sv
// Loads a packed M-ary symbol table over the byte config port and plays it
// out one symbol per programmable period, optionally looping as a beacon.
module fsk_symbol_sequencer
    import fsk_seq_pkg::*;
#(
    parameter int NUM_SYMS = 162,
    parameter int SYM_BITS = 2,
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          cfg_data_in,
    input  logic                cfg_valid_in,
    input  logic                cfg_start,
    input  logic                tx_start,
    input  logic                tx_abort,
    input  logic                repeat_en,
    input  logic [PERIOD_W-1:0] sym_period,
    output logic [SYM_BITS-1:0] sym_out,
    output logic                sym_strobe,
    output logic                tx_active,
    output logic                tx_done,
    output logic                cfg_loaded,
    output logic                cfg_overflow
);

    localparam int NBYTES        = nbytes(NUM_SYMS, SYM_BITS);
    localparam int SYMS_PER_BYTE = syms_per_byte(SYM_BITS);
    localparam int IDX_W         = idx_width(NUM_SYMS);
    localparam int PTR_W         = idx_width(NBYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYMS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NBYTES - 1);

    seq_state_e          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                loaded_q, loaded_d;
    logic                overflow_q, overflow_d;
    logic                strobe_q, strobe_d;
    logic                done_q, done_d;
    logic                tab_we;
    logic                timer_load;
    logic                timer_expire;

    logic [SYM_BITS-1:0] sym_tab_q [NUM_SYMS];
    logic [SYM_BITS-1:0] sym_tab_d [NUM_SYMS];
    logic [SYM_BITS-1:0] lane_sym  [SYMS_PER_BYTE];

    // Lowest-order bits of each byte hold the earliest symbol.
    for (genvar gi = 0; gi < SYMS_PER_BYTE; gi++) begin : g_lane
        assign lane_sym[gi] = cfg_data_in[gi*SYM_BITS +: SYM_BITS];
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        loaded_d   = loaded_q;
        overflow_d = overflow_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
        tab_we     = 1'b0;
        timer_load = 1'b0;

        unique case (state_q)
            IDLE, ARMED: begin
                if (cfg_start) begin
                    state_d    = LOAD;
                    ptr_d      = '0;
                    loaded_d   = 1'b0;
                    overflow_d = 1'b0;
                end else begin
                    if (cfg_valid_in) overflow_d = 1'b1;
                    if ((state_q == ARMED) && tx_start) begin
                        state_d    = TX;
                        idx_d      = '0;
                        strobe_d   = 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (cfg_start) begin
                    ptr_d = '0;
                end else if (cfg_valid_in) begin
                    tab_we = 1'b1;
                    ptr_d  = ptr_q + PTR_W'(1);
                    if (ptr_q == LAST_PTR) begin
                        state_d  = ARMED;
                        loaded_d = 1'b1;
                    end
                end
            end
            TX: begin
                if (cfg_valid_in) overflow_d = 1'b1;
                // Abort is checked first so it beats a coincident frame end.
                if (tx_abort) begin
                    state_d = ARMED;
                    idx_d   = '0;
                end else if (timer_expire) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (repeat_en) begin
                            strobe_d = 1'b1;
                        end else begin
                            state_d = ARMED;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        strobe_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sym_tab_d = sym_tab_q;
        if (tab_we) begin
            for (int i = 0; i < NUM_SYMS; i++) begin
                if (ptr_q == PTR_W'(i / SYMS_PER_BYTE)) begin
                    sym_tab_d[i] = lane_sym[i % SYMS_PER_BYTE];
                end
            end
        end
    end

    // Table contents survive reset; cfg_loaded alone gates their use.
    always_ff @(posedge clk) begin
        sym_tab_q <= sym_tab_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            loaded_q   <= 1'b0;
            overflow_q <= 1'b0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            loaded_q   <= loaded_d;
            overflow_q <= overflow_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
        end
    end

    sym_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .en     (state_q == TX),
        .period (sym_period),
        .expire (timer_expire)
    );

    assign tx_active    = (state_q == TX);
    assign sym_out      = (state_q == TX) ? sym_tab_q[idx_q] : '0;
    assign sym_strobe   = strobe_q;
    assign tx_done      = done_q;
    assign cfg_loaded   = loaded_q;
    assign cfg_overflow = overflow_q;

endmodule
